conv_encoder_frame: RTL

Parametrised, frame-based rate-1/2 convolutional encoder that generates the 2-bit code symbols consumed by the Viterbi decoder's `rx`/`seq_rdy`/`data_ack` handshake. Constraint length, generator polynomials and frame length are parameters. The encoder zeroes its shift register at every frame start and optionally appends K-1 zero tail symbols, so every frame starts and ends in state 0 for the decoder.

---
 rtl/conv_encoder_frame.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_frame.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_encoder_frame                                         |
// | Description : Frame-based rate-1/2 convolutional encoder. Each frame     |
// |               starts from an all-zero shift register and, when the       |
// |               CONV_TAIL_FLUSH_EN macro is defined, is closed with K-1    |
// |               zero tail symbols so the trellis ends in state 0.          |
// |               Symbols are offered on sym/seq_rdy and consumed with       |
// |               data_ack.                                                  |
// | Options     : `define CONV_TAIL_FLUSH_EN to compile in the tail flush.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv_encoder_frame #(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int           FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] sym,
    output logic       seq_rdy,
    input  logic       data_ack,
    output logic       busy,
    output logic       frame_done
);

    localparam int c_cnt_w = $clog2(FRAME_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(FRAME_LEN - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_data  = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
`ifdef CONV_TAIL_FLUSH_EN
    localparam logic [1:0] c_tail       = 2'd3;
    localparam logic [1:0] c_after_data = c_tail;
    localparam int         c_tail_w     = $clog2(K);
    localparam logic [c_tail_w-1:0] c_last_tail = c_tail_w'(K - 2);
`else
    localparam logic [1:0] c_after_data = c_drain;
`endif

    logic [1:0]         r_state;
    logic [K-2:0]       r_sr;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [1:0]         r_sym;
    logic               r_seq_rdy;
    logic               r_frame_done;
`ifdef CONV_TAIL_FLUSH_EN
    logic [c_tail_w-1:0] r_tail_cnt;
`endif

    logic         w_u;
    logic [K-1:0] w_taps;
    logic [K-2:0] w_sr_shift;
    logic [1:0]   w_sym;
    logic         w_slot_free;
    logic         w_accept;
    logic         w_consume;
    logic         w_load;

    // Data bits feed the encoder in IDLE/DATA; in the tail the input is forced to zero.
    assign w_u = in_bit & ((r_state == c_idle) || (r_state == c_data));

    // Tap vector {u, sr[0], ..., sr[K-2]} MSB first, and the shifted register image.
    always_comb begin
        w_taps        = '0;
        w_sr_shift    = '0;
        w_taps[K-1]   = w_u;
        for (int i = 0; i < K - 1; i++) begin
            w_taps[K-2-i] = r_sr[i];
        end
        w_sr_shift[0] = w_u;
        for (int i = 1; i < K - 1; i++) begin
            w_sr_shift[i] = r_sr[i-1];
        end
    end

    assign w_sym       = {^(G0 & w_taps), ^(G1 & w_taps)};
    assign w_slot_free = !r_seq_rdy || data_ack;
    assign in_ready    = ((r_state == c_idle) || (r_state == c_data)) && w_slot_free && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_consume   = r_seq_rdy && data_ack;
`ifdef CONV_TAIL_FLUSH_EN
    assign w_load      = w_accept || ((r_state == c_tail) && w_slot_free);
`else
    assign w_load      = w_accept;
`endif

    assign sym        = r_sym;
    assign seq_rdy    = r_seq_rdy;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != c_idle);

    // Frame FSM together with the output symbol slot and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_sym        <= 2'b00;
            r_seq_rdy    <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef CONV_TAIL_FLUSH_EN
            r_tail_cnt   <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;

            // A load always wins over a consume, so a same-edge consume+load keeps seq_rdy high.
            if (w_load) begin
                r_sym     <= w_sym;
                r_seq_rdy <= 1'b1;
            end else if (w_consume) begin
                r_seq_rdy <= 1'b0;
            end

            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_sr      <= w_sr_shift;
                        r_bit_cnt <= c_cnt_w'(1);
                        r_state   <= (FRAME_LEN == 1) ? c_after_data : c_data;
                    end
                end
                c_data: begin
                    if (w_accept) begin
                        r_sr      <= w_sr_shift;
                        r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= c_after_data;
                        end
                    end
                end
`ifdef CONV_TAIL_FLUSH_EN
                c_tail: begin
                    if (w_slot_free) begin
                        r_sr       <= w_sr_shift;
                        r_tail_cnt <= r_tail_cnt + c_tail_w'(1);
                        if (r_tail_cnt == c_last_tail) begin
                            r_state <= c_drain;
                        end
                    end
                end
`endif
                c_drain: begin
                    if (w_consume) begin
                        r_frame_done <= 1'b1;
                        r_sr         <= '0;
                        r_bit_cnt    <= '0;
`ifdef CONV_TAIL_FLUSH_EN
                        r_tail_cnt   <= '0;
`endif
                        r_state      <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
